// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: starts CNN layer engines in order and tracks which are active.
// Optional early overlap on pipe_done is enabled by defining CNN_PIPELINE_START_EN.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS = 7,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [NUM_LAYERS-1:0] layer_pipe_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [NUM_LAYERS-1:0] layer_active,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  cnn_done,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  seq_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_LAYERS);

  state_e                state_q;
  logic [3:0]            next_idx_q;
  logic [NUM_LAYERS-1:0] done_mask_q;
  logic [NUM_LAYERS-1:0] active_q;
  logic [NUM_LAYERS-1:0] start_q;
  logic [2:0]            cur_layer_q;
  logic                  busy_q;
  logic                  cnn_done_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  seq_err_q;

  logic [NUM_LAYERS-1:0] pipe_eff;
  logic [NUM_LAYERS-1:0] sel_prev;
  logic [NUM_LAYERS-1:0] sel_next;
  logic [NUM_LAYERS-1:0] done_acc;
  logic [NUM_LAYERS-1:0] done_mask_d;
  logic [NUM_LAYERS-1:0] active_d;
  logic                  trig;
  logic                  err_hit;

`ifdef CNN_PIPELINE_START_EN
  assign pipe_eff = layer_pipe_done;
`else
  logic unused_pipe;
  assign unused_pipe = ^layer_pipe_done;
  assign pipe_eff    = '0;
`endif

  // One-hot selects for the layer being watched and the layer to launch next
  always_comb begin
    sel_prev = '0;
    sel_next = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      sel_prev[i] = (4'(i) == (next_idx_q - 4'd1));
      sel_next[i] = (4'(i) == next_idx_q);
    end
  end

  // Advance trigger, accepted completions and out-of-order pulse detection
  always_comb begin
    trig = (state_q == RUN)
        && (next_idx_q < LAST_IDX)
        && (|(sel_prev & active_q & (layer_done | pipe_eff)));
    done_acc    = layer_done & active_q;
    done_mask_d = done_mask_q | done_acc;
    active_d    = (active_q & ~done_acc) | (trig ? sel_next : '0);
    err_hit     = |((layer_done | pipe_eff) & ~active_q);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      next_idx_q  <= '0;
      done_mask_q <= '0;
      active_q    <= '0;
      start_q     <= '0;
      cur_layer_q <= '0;
      busy_q      <= 1'b0;
      cnn_done_q  <= 1'b0;
      cnt_q       <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      start_q    <= '0;
      cnn_done_q <= 1'b0;
      if (err_hit) seq_err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            next_idx_q  <= 4'd1;
            done_mask_q <= '0;
            active_q    <= {{(NUM_LAYERS-1){1'b0}}, 1'b1};
            start_q     <= {{(NUM_LAYERS-1){1'b0}}, 1'b1};
            cur_layer_q <= '0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            seq_err_q   <= 1'b0;
          end
        end
        RUN: begin
          active_q    <= active_d;
          done_mask_q <= done_mask_d;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (trig) begin
            start_q     <= sel_next;
            cur_layer_q <= next_idx_q[2:0];
            next_idx_q  <= next_idx_q + 4'd1;
          end
          if (&done_mask_d) begin
            state_q    <= FINISH;
            cnn_done_q <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign layer_start  = start_q;
  assign layer_active = active_q;
  assign cur_layer    = cur_layer_q;
  assign busy         = busy_q;
  assign cnn_done     = cnn_done_q;
  assign cycle_count  = cnt_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed vectors plus engine-model runs.
// Overlap expectations follow CNN_PIPELINE_START_EN.
module tb_cnn_layer_sequencer;

  localparam int NL = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_pipe_done;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_active;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          cnn_done;
  logic [CW-1:0] cycle_count;
  logic          seq_err;

  int checks = 0;
  int errors = 0;

  int ls_at[NL];
  int cnn_at;
  int ovl;
  bit err_seen;

  typedef struct {
    logic        st;
    logic [2:0]  dn;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[11];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .layer_done(layer_done),
    .layer_pipe_done(layer_pipe_done),
    .layer_start(layer_start),
    .layer_active(layer_active),
    .cur_layer(cur_layer),
    .busy(busy),
    .cnn_done(cnn_done),
    .cycle_count(cycle_count),
    .seq_err(seq_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    layer_done = '0;
    layer_pipe_done = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] dn,
                              input logic [2:0] ls, input logic [2:0] act,
                              input logic [2:0] cur, input logic b,
                              input logic c, input logic e);
    vec_t v;
    v.st  = st;
    v.dn  = dn;
    v.exp = {ls, act, cur, b, c, e};
    return v;
  endfunction

  // Engines raise done 10 cycles after their start; engine 0 may
  // also raise pipe_done 4 cycles after its start.
  task automatic run_sched(input bit pipe0);
    int s[NL];
    for (int i = 0; i < NL; i++) begin
      s[i] = -100;
      ls_at[i] = -1;
    end
    cnn_at = -1;
    ovl = 0;
    err_seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 100 && cnn_at < 0; n++) begin
      for (int i = 0; i < NL; i++) begin
        if (layer_start[i]) begin
          if (ls_at[i] < 0) ls_at[i] = n;
          s[i] = n;
        end
      end
      if (cnn_done && cnn_at < 0) cnn_at = n;
      if (layer_active == 3'b011) ovl++;
      if (seq_err) err_seen = 1'b1;
      for (int i = 0; i < NL; i++) begin
        layer_done[i] = (n + 1 == s[i] + 11);
        layer_pipe_done[i] = pipe0 && (i == 0) && (n + 1 == s[i] + 5);
      end
      if (cnn_at < 0) step();
    end
    layer_done = '0;
    layer_pipe_done = '0;
  endtask

  initial begin
    int e_ls1, e_ls2, e_cnn, e_ovl, pulses;

    vt[0]  = mk(1'b1, 3'b000, 3'b001, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 3'b000, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 3'b100, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0, 1'b1);
    vt[4]  = mk(1'b0, 3'b001, 3'b010, 3'b010, 3'd1, 1'b1, 1'b0, 1'b1);
    vt[5]  = mk(1'b0, 3'b010, 3'b100, 3'b100, 3'd2, 1'b1, 1'b0, 1'b1);
    vt[6]  = mk(1'b0, 3'b000, 3'b000, 3'b100, 3'd2, 1'b1, 1'b0, 1'b1);
    vt[7]  = mk(1'b0, 3'b101, 3'b000, 3'b000, 3'd2, 1'b1, 1'b1, 1'b1);
    vt[8]  = mk(1'b0, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 3'b000, 3'b001, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0);
    vt[10] = mk(1'b0, 3'b001, 3'b010, 3'b010, 3'd1, 1'b1, 1'b0, 1'b0);

    do_reset();
    chk("reset_outs", {layer_start, layer_active, cur_layer,
                       busy, cnn_done, seq_err}, 32'h0);
    chk("reset_cnt", 32'(cycle_count), 32'h0);

    for (int i = 0; i < 11; i++) begin
      start = vt[i].st;
      layer_done = vt[i].dn;
      step();
      chk($sformatf("vec%0d", i), {layer_start, layer_active, cur_layer,
                                    busy, cnn_done, seq_err}, 32'(vt[i].exp));
    end
    start = 1'b0;
    layer_done = '0;

    rst = 1'b1;
    #1;
    chk("midrun_rst_outs", {layer_start, layer_active, cur_layer,
                            busy, cnn_done, seq_err}, 32'h0);
    chk("midrun_rst_cnt", 32'(cycle_count), 32'h0);
    step();
    chk("rst_held_no_start", 32'(layer_start), 32'h0);
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_ls", 32'(layer_start), 32'h1);
    chk("restart_busy", 32'(busy), 32'h1);

    do_reset();
    run_sched(1'b0);
    chk("ser_ls0", 32'(ls_at[0]), 32'd0);
    chk("ser_ls1", 32'(ls_at[1]), 32'd11);
    chk("ser_ls2", 32'(ls_at[2]), 32'd22);
    chk("ser_cnn", 32'(cnn_at), 32'd33);
    chk("ser_err", 32'(err_seen), 32'd0);
    step();
    chk("ser_busy_low", 32'(busy), 32'd0);
    chk("ser_cnt", 32'(cycle_count), 32'd34);
    step();
    step();
    step();
    chk("ser_cnt_hold", 32'(cycle_count), 32'd34);
    chk("ser_cnn_once", 32'(cnn_done), 32'd0);

`ifdef CNN_PIPELINE_START_EN
    e_ls1 = 5;
    e_ovl = 6;
`else
    e_ls1 = 11;
    e_ovl = 0;
`endif
    e_ls2 = e_ls1 + 11;
    e_cnn = e_ls2 + 11;
    do_reset();
    run_sched(1'b1);
    chk("ovl_ls0", 32'(ls_at[0]), 32'd0);
    chk("ovl_ls1", 32'(ls_at[1]), 32'(e_ls1));
    chk("ovl_ls2", 32'(ls_at[2]), 32'(e_ls2));
    chk("ovl_cnn", 32'(cnn_at), 32'(e_cnn));
    chk("ovl_active011", 32'(ovl), 32'(e_ovl));
    chk("ovl_err", 32'(err_seen), 32'd0);
    step();
    chk("ovl_cnt", 32'(cycle_count), 32'(e_cnn + 1));

    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    layer_done = 3'b001;
    layer_pipe_done = 3'b001;
    step();
    layer_done = '0;
    layer_pipe_done = '0;
    chk("coinc_ls", 32'(layer_start), 32'h2);
    chk("coinc_act", 32'(layer_active), 32'h2);
    chk("coinc_cur", 32'(cur_layer), 32'h1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (layer_start != '0) pulses++;
    end
    chk("coinc_single", 32'(pulses), 32'd0);
    chk("coinc_act_hold", 32'(layer_active), 32'h2);
    chk("coinc_err", 32'(seq_err), 32'd0);
    layer_pipe_done = 3'b100;
    step();
    layer_pipe_done = '0;
`ifdef CNN_PIPELINE_START_EN
    chk("pipe_inactive_err", 32'(seq_err), 32'd1);
`else
    chk("pipe_inactive_err", 32'(seq_err), 32'd0);
`endif
    chk("pipe_inactive_ls", 32'(layer_start), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level scheduler for the CNN accelerator layer engines (conv, maxpooling, FC). It launches each layer engine in order with a one-cycle start pulse and tracks which engines are active. It advances to the next layer on that engine's completion, or early on its pipeline-done indication when overlap is compiled in, and reports overall completion and a cycle count to the CPU-side wrapper.

## Interface
- NUM_LAYERS, default 7: number of sequenced layer engines (2..8); layer 0 runs first.
- CNT_W, default 32: width of the run cycle counter.
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  run request pulse from wrapper; sampled only in IDLE
- layer_done  input  NUM_LAYERS  per-engine completion pulse (engine's calculation_done)
- layer_pipe_done  input  NUM_LAYERS  per-engine early-overlap pulse (engine's pipeline_calculation_done)
- layer_start  output  NUM_LAYERS  per-engine start pulse; at most one bit high per cycle
- layer_active  output  NUM_LAYERS  level; bit i high from layer_start[i] until layer_done[i] is accepted
- cur_layer  output  3  index of the most recently started layer
- busy  output  1  high in RUN and FINISH
- cnn_done  output  1  one-cycle pulse when the last layer completes
- cycle_count  output  CNT_W  cycles spent busy in the current or last run
- seq_err  output  1  sticky; a done or pipe_done pulse arrived from a non-active layer

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1:
  - register next_idx=1 and pulse layer_start[0];
  - set layer_active[0], clear cycle_count and seq_err;
  - go to RUN.
- RUN, advance trigger for layer k=next_idx-1 is layer_done[k], or (with overlap) layer_pipe_done[k], while layer_active[k]=1 and next_idx<NUM_LAYERS.
- RUN, on trigger:
  - pulse layer_start[next_idx] and set its active bit;
  - cur_layer<=next_idx and increment next_idx;
  - each layer is started exactly once per run.
- RUN, layer_done[i] with layer_active[i]=1 clears layer_active[i] and sets done_mask[i].
- RUN, done_mask all ones (last done accepted): go to FINISH.
- FINISH: cnn_done=1 for one cycle, then IDLE. Wrapper must not drive start in FINISH.
- Pulses from inactive layers are ignored for sequencing and set seq_err; seq_err is cleared only by rst or a new start.
- start while busy is ignored.
- cycle_count:
  - increments every cycle in RUN and FINISH;
  - saturates at all ones;
  - holds in IDLE.

## Timing
- All outputs are registered.
- Reset values: layer_start=0, layer_active=0, cur_layer=0, busy=0, cnn_done=0, cycle_count=0, seq_err=0, state IDLE, next_idx=0, done_mask=0.
- start at edge t: layer_start[0]=1 and busy=1 during cycle t+1.
- Trigger at edge t: layer_start[k+1] high during cycle t+1 only.
- layer_done[i] at edge t: layer_active[i] low in cycle t+1.
- Last layer_done at edge t: FINISH/cnn_done in cycle t+1, busy low in t+2.
- pipe_done[k] and done[k] at the same edge: exactly one start of k+1; layer_active[k] clears.
- pipe_done[k] then a later done[k]: the done only clears the active bit; no second start.
- Simultaneous done on two active layers: both accepted in the same cycle.
- Trigger on the same edge as the last layer's done is impossible by construction. The last layer has no successor; its pipe_done is accepted silently.
- rst mid-run: all state and outputs return to reset values immediately; engines receive no further starts.

## Configuration
- CNN_PIPELINE_START_EN defined: layer_pipe_done[k] is a valid advance trigger, so up to two adjacent layers can be active at once.
- CNN_PIPELINE_START_EN undefined:
  - layer_pipe_done is ignored entirely (no start, no seq_err);
  - only layer_done advances, so at most one layer is active;
  - cycle counts grow accordingly.

## Test plan
- Reset during RUN (NUM_LAYERS=3):
  - start, wait for layer_start[1], assert rst 1 cycle;
  - all outputs 0, state IDLE;
  - a following start pulses layer_start[0] again.
- Serial run (macro off, NUM_LAYERS=3):
  - start at t0; each engine model raises done 10 cycles after its start;
  - layer_start bits at t0+1, t0+12, t0+23;
  - cnn_done at t0+34; cycle_count=34.
- Overlap run (macro on):
  - engine 0 pulses pipe_done 4 cycles after start, done at 10;
  - layer_start[1] 5 cycles after layer_start[0];
  - layer_active=3'b011 for the overlapping cycles.
- Coincident pulses (macro on):
  - pipe_done[0] and done[0] on the same edge;
  - single layer_start[1] pulse; layer_active[0] cleared next cycle.
- Error and ignore:
  - layer_done[2] while only layer 0 active sets seq_err=1 with no state change;
  - start during RUN produces no layer_start;
  - a new start clears seq_err.
- Last-layer completion:
  - done[NUM_LAYERS-1] gives cnn_done one cycle, then busy=0;
  - cycle_count holds its value in IDLE.
